// File: rtl/telemetry_framer_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the telemetry framer.
package telemetry_framer_pkg;

    localparam logic [7:0] SYNC0_DEF       = 8'hA5;
    localparam logic [7:0] SYNC1_DEF       = 8'h5A;
    localparam int         FIRST_ADDR_DEF  = 1;
    localparam int         LAST_ADDR_DEF   = 34;
    localparam int         PAYLOAD_LEN_DEF = LAST_ADDR_DEF - FIRST_ADDR_DEF + 1;
    localparam int         FRAME_BYTES_DEF = PAYLOAD_LEN_DEF + 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    // Byte that brings the running modulo-256 sum back to zero.
    function automatic logic [7:0] csum_close(input logic [7:0] acc);
        return 8'h00 - acc;
    endfunction

endpackage

// File: rtl/telemetry_rate_timer.sv
// Free-running frame trigger: one-cycle tick every PERIOD cycles while enabled.
module telemetry_rate_timer #(
    parameter int PERIOD = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(PERIOD - 1));
    assign tick   = enable && at_end;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// Sweeps the register bank and streams a framed packet (sync, seq, len, payload, checksum)
// one byte at a time over a valid/ready link.
module telemetry_framer
    import telemetry_framer_pkg::*;
#(
    parameter int         FIRST_ADDR = FIRST_ADDR_DEF,
    parameter int         LAST_ADDR  = LAST_ADDR_DEF,
    parameter int         PERIOD     = 500000,
    parameter logic [7:0] SYNC0      = SYNC0_DEF,
    parameter logic [7:0] SYNC1      = SYNC1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] seq,
    output logic [7:0] overrun_cnt
);

    localparam logic [7:0] LEN = 8'(LAST_ADDR - FIRST_ADDR + 1);

    state_t     state, state_next;
    logic [1:0] hdr_cnt, hdr_cnt_next;
    logic [7:0] csum, csum_next;
    logic [7:0] tx_data_next, reg_addr_next, seq_next, overrun_next;
    logic       tx_valid_next, busy_next;
    logic       tick, xfer, at_last;

    telemetry_rate_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign xfer    = tx_valid && tx_ready;
    assign at_last = (reg_addr == 8'(LAST_ADDR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr_cnt     <= 2'd0;
            csum        <= 8'h00;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            reg_addr    <= 8'h00;
            busy        <= 1'b0;
            seq         <= 8'h00;
            overrun_cnt <= 8'h00;
        end else begin
            state       <= state_next;
            hdr_cnt     <= hdr_cnt_next;
            csum        <= csum_next;
            tx_data     <= tx_data_next;
            tx_valid    <= tx_valid_next;
            reg_addr    <= reg_addr_next;
            busy        <= busy_next;
            seq         <= seq_next;
            overrun_cnt <= overrun_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = HDR;
            HDR:     if (xfer && hdr_cnt == 2'd3) state_next = FETCH;
            FETCH:   state_next = LATCH;
            LATCH:   state_next = PAYLOAD;
            PAYLOAD: if (xfer) state_next = at_last ? CSUM : FETCH;
            CSUM:    if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_data_next  = tx_data;
        tx_valid_next = tx_valid;
        reg_addr_next = reg_addr;
        csum_next     = csum;
        busy_next     = busy;
        seq_next      = seq;
        hdr_cnt_next  = hdr_cnt;
        overrun_next  = overrun_cnt;

        // A trigger landing while a frame is in flight is dropped, only counted.
        if (tick && busy && overrun_cnt != 8'hFF) begin
            overrun_next = overrun_cnt + 8'd1;
        end

        case (state)
            IDLE: begin
                if (tick) begin
                    busy_next     = 1'b1;
                    tx_data_next  = SYNC0;
                    tx_valid_next = 1'b1;
                    hdr_cnt_next  = 2'd0;
                end
            end
            HDR: begin
                if (xfer) begin
                    hdr_cnt_next = hdr_cnt + 2'd1;
                    case (hdr_cnt)
                        2'd0:    tx_data_next = SYNC1;
                        2'd1:    tx_data_next = seq;
                        2'd2:    tx_data_next = LEN;
                        default: begin
                            tx_valid_next = 1'b0;
                            reg_addr_next = 8'(FIRST_ADDR);
                            csum_next     = seq + LEN;
                        end
                    endcase
                end
            end
            LATCH: begin
                tx_data_next  = reg_data;
                csum_next     = csum + reg_data;
                tx_valid_next = 1'b1;
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (at_last) begin
                        tx_data_next = csum_close(csum);
                    end else begin
                        tx_valid_next = 1'b0;
                        reg_addr_next = reg_addr + 8'd1;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    tx_valid_next = 1'b0;
                    busy_next     = 1'b0;
                    seq_next      = seq + 8'd1;
                    reg_addr_next = 8'h00;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Downstream consumer of the sensor register bank.
- Periodically sweeps the bank's byte address space (reg_addr → reg_data) and wraps the bytes into a framed telemetry packet: sync, sequence, length, payload, checksum.
- Streams the packet one byte at a time over a valid/ready interface to the downlink UART transmitter.

Parameters:
- FIRST_ADDR, 1, first register-bank byte address read into the payload.
- LAST_ADDR, 34, last register-bank byte address read (inclusive).
- PERIOD, 500000, clk cycles between frame triggers; legal minimum 128.
- SYNC0, 8'hA5, first sync byte.
- SYNC1, 8'h5A, second sync byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new frame triggers; gates the period timer.
- reg_addr  out  8  byte address driven to the sensor register bank.
- reg_data  in  8  byte returned by the register bank (combinational from reg_addr).
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  high from trigger until the checksum byte is accepted.
- seq  out  8  sequence number of the current/last frame.
- overrun_cnt  out  8  count of triggers dropped because busy; saturates at 255.

Behaviour:
- Reset (rst=1 at clk edge) drives: reg_addr=0, tx_data=0, tx_valid=0, busy=0, seq=0, overrun_cnt=0, timer=0, state=IDLE. Reset mid-frame aborts the frame immediately; no partial bytes follow.
- Timer:
  - With enable=1, the timer counts 0..PERIOD-1 and asserts a one-cycle tick at PERIOD-1, then wraps to 0.
  - With enable=0, the timer is held at 0.
  - A tick while busy=1 is dropped and overrun_cnt increments (saturating).
- Frame layout, 39 bytes with default parameters: SYNC0, SYNC1, seq, LEN, payload[FIRST_ADDR..LAST_ADDR], CSUM.
  - LEN = LAST_ADDR-FIRST_ADDR+1 = 34.
  - CSUM = (256 - (seq + LEN + Σpayload) mod 256) mod 256, so the 8-bit sum of seq through CSUM is 0. Sync bytes are excluded.
- Handshake:
  - A byte transfers on a cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid is not withdrawn.
  - tx_valid deasserts the cycle after the last transfer unless a next byte is loaded.
- State machine:
  - IDLE: on tick, busy←1, load tx_data=SYNC0, tx_valid←1, go to HDR. SYNC0 is presented the cycle after the tick.
  - HDR: on each transfer, advance SYNC1 → seq → LEN. On the LEN transfer, tx_valid←0, reg_addr←FIRST_ADDR, checksum accumulator ← seq+LEN; go to FETCH.
  - FETCH: one wait cycle for reg_data to settle; go to LATCH.
  - LATCH: tx_data←reg_data, accumulate into checksum, tx_valid←1; go to PAYLOAD.
  - PAYLOAD: on transfer:
    - If reg_addr==LAST_ADDR, load tx_data=CSUM and go to CSUM.
    - Otherwise tx_valid←0, reg_addr←reg_addr+1, go to FETCH.
  - CSUM: on transfer, tx_valid←0, busy←0, seq←seq+1 (wraps 255→0), reg_addr←0; go to IDLE.
- reg_addr holds its value between FETCH and transfer, so it is stable across backpressure.
- Minimum frame duration with tx_ready tied high: 4 + 3·LEN + 1 = 107 cycles.
- enable deasserted mid-frame: the current frame completes normally.
- Tick coincident with the CSUM transfer: busy is still 1, so the tick is dropped and counted.
- The accumulator is 8-bit with wrap-around; all addition is modulo 256.

Decomposition:
- Shared package: SYNC0/SYNC1 defaults, frame-length constant, state encoding (IDLE, HDR, FETCH, LATCH, PAYLOAD, CSUM).
- One sub-module: telemetry_rate_timer (enable, PERIOD → tick).

Test Plan:
- Zero frame: reset, all sensor inputs 0, PERIOD=200, enable=1, tx_ready=1. Expect a frame at cycle 200: A5,5A,00,22, 34×00, DE; busy high 107 cycles; seq→1.
- Payload mapping: pressure=24'h123456. Expect payload bytes 0–2 = 12,34,56; CSUM recomputes so the sum of seq..CSUM ≡ 0 mod 256.
- Backpressure: tx_ready toggles 1-of-3 cycles. Expect tx_data and reg_addr stable while stalled, byte sequence identical to the no-stall case, no lost or duplicated bytes.
- Overrun: PERIOD=128 with tx_ready low for 300 cycles. Expect overrun_cnt≥1, the first frame completes, and no second frame starts mid-frame.
- Reset mid-payload: assert rst at payload byte 10. Next cycle: tx_valid=0, busy=0, seq=0; the next tick yields a full fresh frame with seq=00.
- Sequence wrap: run 257 frames. Expect seq byte 255 followed by 0, with checksum valid for each.
